// File: rtl/instmem_dual_line.sv
// Dual-line instruction memory: a read returns block idx and block idx+1 (wrapped), a write refills one block; INSTMEM_PRELOAD_EN selects an explicit start-up initialisation of storage.
// Latency: LATENCY cycles from read acceptance to resp_valid; writes commit on the accepting edge with no response.
// Backpressure: the response is held until resp_ready; req_ready stays low from read acceptance until the response is taken.
module instmem_dual_line #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 256,
    parameter int LATENCY     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [8*BLOCK_BYTES-1:0] req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [8*BLOCK_BYTES-1:0] resp_line0,
    output logic [8*BLOCK_BYTES-1:0] resp_line1,
    output logic [ADDR_W-1:0]        resp_addr
);

    localparam int OFF_W     = $clog2(BLOCK_BYTES);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int HI_W      = ADDR_W - OFF_W;
    localparam int BLK_W     = 8 * BLOCK_BYTES;
    localparam int MEM_BYTES = DEPTH * BLOCK_BYTES;
    localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [HI_W-1:0]   addr_hi_q;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx0;
    logic [IDX_W-1:0]  rd_idx1;
    logic [BLK_W-1:0]  rd_line0;
    logic [BLK_W-1:0]  rd_line1;
    logic              acc_rd;
    logic              acc_wr;
    logic              addr_off_unused;

    // Byte-organised storage; contents survive rst_n.
`ifdef INSTMEM_PRELOAD_EN
    logic [7:0] mem [MEM_BYTES];

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i] = 8'h00;
        end
    end
`else
    logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
`endif

    assign addr_off_unused = ^req_addr[OFF_W-1:0];

    assign acc_rd  = req_valid && req_ready && !req_we;
    assign acc_wr  = req_valid && req_ready && req_we;
    assign req_idx = req_addr[OFF_W +: IDX_W];

    // In IDLE the read port looks at the incoming address so LATENCY=1 can load on acceptance.
    assign rd_idx0 = (state == IDLE) ? req_idx : addr_hi_q[IDX_W-1:0];
    assign rd_idx1 = rd_idx0 + IDX_W'(1);

    always_comb begin
        rd_line0 = '0;
        rd_line1 = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            rd_line0[8*(BLOCK_BYTES-i)-1 -: 8] = mem[{rd_idx0, OFF_W'(i)}];
            rd_line1[8*(BLOCK_BYTES-i)-1 -: 8] = mem[{rd_idx1, OFF_W'(i)}];
        end
    end

    // A write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && acc_wr) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                mem[{req_idx, OFF_W'(i)}] <= req_wdata[8*(BLOCK_BYTES-i)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_hi_q  <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_line0 <= '0;
            resp_line1 <= '0;
            resp_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (acc_rd) begin
                        addr_hi_q <= req_addr[ADDR_W-1:OFF_W];
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            resp_line0 <= rd_line0;
                            resp_line1 <= rd_line1;
                            resp_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            cnt   <= CNT_W'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Counter hits zero on this edge: capture both lines now.
                    if (cnt == CNT_W'(1)) begin
                        resp_line0 <= rd_line0;
                        resp_line1 <= rd_line1;
                        resp_addr  <= {addr_hi_q, {OFF_W{1'b0}}};
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instmem_dual_line.sv
// Directed bench for instmem_dual_line with a scoreboard queue of expected read responses.
module tb_instmem_dual_line;

    localparam int AW  = 32;
    localparam int BB  = 16;
    localparam int DP  = 256;
    localparam int LAT = 2;
    localparam int BW  = 8 * BB;

    localparam logic [BW-1:0] PAT5 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    typedef struct {
        logic [BW-1:0] l0;
        logic [BW-1:0] l1;
        logic [AW-1:0] a;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [BW-1:0] resp_line0;
    logic [BW-1:0] resp_line1;
    logic [AW-1:0] resp_addr;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    instmem_dual_line #(
        .ADDR_W     (AW),
        .BLOCK_BYTES(BB),
        .DEPTH      (DP),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_line0(resp_line0),
        .resp_line1(resp_line1),
        .resp_addr (resp_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] fill(input logic [7:0] b);
        return {BB{b}};
    endfunction

    task automatic check_vec(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic write_blk(input logic [AW-1:0] a, input logic [BW-1:0] d);
        check_bit("wr_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic [BW-1:0] e0,
                              input logic [BW-1:0] e1, input logic push);
        exp_t e;
        check_bit("rd_req_ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        if (push) begin
            e.l0 = e0;
            e.l1 = e1;
            e.a  = {a[AW-1:4], 4'h0};
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called in the cycle after acceptance; returns on the first cycle resp_valid is seen.
    task automatic wait_resp();
        int   lat = 1;
        exp_t e;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_vec("resp_latency", BW'(lat), BW'(LAT));
        check_bit("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_vec("resp_line0", resp_line0, e.l0);
            check_vec("resp_line1", resp_line1, e.l1);
            check_vec("resp_addr", BW'(resp_addr), BW'(e.a));
        end
    endtask

    task automatic end_resp();
        @(negedge clk);
        check_bit("resp_valid_drop", resp_valid, 1'b0);
        check_bit("idle_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_resp_valid", resp_valid, 1'b0);
        check_vec("rst_line0", resp_line0, '0);
        check_vec("rst_line1", resp_line1, '0);
        check_vec("rst_addr", BW'(resp_addr), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("ready_after_release", req_ready, 1'b1);

        // Read of unwritten storage.
        issue_read(32'h0, '0, '0, 1'b1);
        wait_resp();
        end_resp();

        // Write then read straddling blocks 5 and 6 (read follows write immediately).
        write_blk(32'h50, PAT5);
        write_blk(32'h60, fill(8'hA5));
        issue_read(32'h53, PAT5, fill(8'hA5), 1'b1);
        wait_resp();
        end_resp();

        // Wrap of the last block and upper-address aliasing.
        write_blk(32'hFF0, fill(8'h11));
        write_blk(32'h000, fill(8'h22));
        issue_read(32'hFF7, fill(8'h11), fill(8'h22), 1'b1);
        wait_resp();
        end_resp();
        issue_read(32'h1000, fill(8'h22), '0, 1'b1);
        wait_resp();
        end_resp();

        // Backpressure with a competing write request held on the request channel.
        resp_ready = 1'b0;
        issue_read(32'h50, PAT5, fill(8'hA5), 1'b1);
        wait_resp();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h60;
        req_wdata = fill(8'h5A);
        repeat (3) begin
            @(negedge clk);
            check_bit("bp_resp_valid", resp_valid, 1'b1);
            check_bit("bp_req_ready", req_ready, 1'b0);
            check_vec("bp_line0", resp_line0, PAT5);
            check_vec("bp_line1", resp_line1, fill(8'hA5));
            check_vec("bp_addr", BW'(resp_addr), BW'(32'h50));
        end
        req_valid  = 1'b0;
        req_we     = 1'b0;
        resp_ready = 1'b1;
        end_resp();
        issue_read(32'h50, PAT5, fill(8'hA5), 1'b1);
        wait_resp();
        end_resp();

        // Reset one cycle after read acceptance drops the read.
        issue_read(32'h60, fill(8'hA5), '0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("mid_rst_valid", resp_valid, 1'b0);
        check_bit("mid_rst_ready", req_ready, 1'b0);
        check_vec("mid_rst_line0", resp_line0, '0);
        check_vec("mid_rst_line1", resp_line1, '0);
        check_vec("mid_rst_addr", BW'(resp_addr), '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check_bit("no_stale_resp", seen, 1'b0);
        issue_read(32'h60, fill(8'hA5), '0, 1'b1);
        wait_resp();
        end_resp();

        // Back-to-back writes to blocks 0..3.
        write_blk(32'h00, fill(8'hC0));
        write_blk(32'h10, fill(8'hC1));
        write_blk(32'h20, fill(8'hC2));
        write_blk(32'h30, fill(8'hC3));
        issue_read(32'h10, fill(8'hC1), fill(8'hC2), 1'b1);
        wait_resp();
        end_resp();

        // Write coinciding with reset is discarded.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = fill(8'hFF);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        issue_read(32'h20, fill(8'hC2), fill(8'hC3), 1'b1);
        wait_resp();
        end_resp();

        check_vec("sb_drained", BW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
